// File: rtl/seg7_display_arbiter.sv
// seg7_display_arbiter: fixed-priority owner selection for the shared 4-digit display,
// with a minimum hold per grant, a frozen linger after early release, and optional blinking.
module seg7_display_arbiter #(
    parameter int NUM_REQ      = 4,
    parameter int HOLD_CYCLES  = 50_000_000,
    parameter int BLINK_CYCLES = 25_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [NUM_REQ-1:0]     req,
    input  logic [NUM_REQ*16-1:0]  req_bcd,
    input  logic [NUM_REQ-1:0]     req_blink,
    output logic [NUM_REQ-1:0]     grant,
    output logic [2:0]             owner_id,
    output logic                   valid,
    output logic [3:0]             bcd_data_0,
    output logic [3:0]             bcd_data_1,
    output logic [3:0]             bcd_data_2,
    output logic [3:0]             bcd_data_3
);
    localparam int HW = $clog2(HOLD_CYCLES + 1);
    localparam int BW = $clog2(BLINK_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, SHOW, LINGER} state_t;

    state_t               state_q, state_d;
    logic [2:0]           owner_q, owner_d;
    logic [HW-1:0]        hold_cnt_q, hold_cnt_d;
    logic [BW-1:0]        blink_cnt_q, blink_cnt_d;
    logic                 phase_q, phase_d;
    logic                 blink_q, blink_d;
    logic [15:0]          bcd_q, bcd_d;
    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic                 valid_q, valid_d;

    // Padded copies so a 3-bit owner index is always in range.
    logic [7:0]           req_x, blink_x;
    logic [127:0]         bcd_x;
    logic [2:0]           pick;
    logic                 any_req, expired, own_req, new_grant, wrap, restart;

    assign req_x   = 8'(req);
    assign blink_x = 8'(req_blink);
    assign bcd_x   = 128'(req_bcd);

    always_comb begin
        pick = 3'd0;
        for (int i = NUM_REQ - 1; i >= 0; i--)
            if (req_x[i]) pick = 3'(i);
        any_req   = |req;
        expired   = hold_cnt_q == '0;
        own_req   = req_x[owner_q];
        new_grant = 1'b0;
        state_d   = state_q;
        owner_d   = owner_q;
        case (state_q)
            IDLE:    new_grant = any_req;
            SHOW:
                if (own_req) new_grant = expired && pick != owner_q;
                else if (!expired) state_d = LINGER;
                else if (any_req) new_grant = 1'b1;
                else state_d = IDLE;
            LINGER:
                if (!expired) state_d = own_req ? SHOW : LINGER;
                else if (any_req) new_grant = 1'b1;
                else state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (new_grant) begin
            state_d = SHOW;
            owner_d = pick;
        end
        if (state_d == IDLE) owner_d = 3'd0;
        hold_cnt_d  = new_grant ? HOLD_LOAD : expired ? hold_cnt_q : hold_cnt_q - HW'(1);
        wrap        = blink_cnt_q == BLINK_LAST;
        restart     = new_grant || state_d == IDLE;
        blink_cnt_d = (restart || wrap) ? '0 : blink_cnt_q + BW'(1);
        phase_d     = restart ? 1'b0 : phase_q ^ wrap;
        blink_d     = state_d == SHOW ? blink_x[owner_d] : state_d == LINGER ? blink_q : 1'b0;
        bcd_d       = state_d == SHOW ? bcd_x[{owner_d, 4'b0000} +: 16] : state_d == LINGER ? bcd_q : 16'h0;
        grant_d     = state_d == IDLE ? '0 : NUM_REQ'(8'd1 << owner_d);
        valid_d     = state_d != IDLE && !(blink_d && phase_d);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            owner_q     <= 3'd0;
            hold_cnt_q  <= '0;
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            blink_q     <= 1'b0;
            bcd_q       <= 16'h0;
            grant_q     <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            hold_cnt_q  <= hold_cnt_d;
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            blink_q     <= blink_d;
            bcd_q       <= bcd_d;
            grant_q     <= grant_d;
            valid_q     <= valid_d;
        end
    end

    assign grant      = grant_q;
    assign owner_id   = owner_q;
    assign valid      = valid_q;
    assign bcd_data_0 = bcd_q[3:0];
    assign bcd_data_1 = bcd_q[7:4];
    assign bcd_data_2 = bcd_q[11:8];
    assign bcd_data_3 = bcd_q[15:12];
endmodule

// File: tb/tb_seg7_display_arbiter.sv
// tb_seg7_display_arbiter: directed scenarios plus random traffic, checked against
// a model that tracks owner, grant age and live/frozen digits.
module tb_seg7_display_arbiter;
    localparam int N = 4;
    localparam int H = 4;
    localparam int B = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*16-1:0] req_bcd = '0;
    logic [N-1:0]   req_blink = '0;
    logic [N-1:0]   grant;
    logic [2:0]     owner_id;
    logic           valid;
    logic [3:0]     bcd_data_0, bcd_data_1, bcd_data_2, bcd_data_3;

    seg7_display_arbiter #(.NUM_REQ(N), .HOLD_CYCLES(H), .BLINK_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .req_bcd(req_bcd), .req_blink(req_blink),
        .grant(grant), .owner_id(owner_id), .valid(valid),
        .bcd_data_0(bcd_data_0), .bcd_data_1(bcd_data_1),
        .bcd_data_2(bcd_data_2), .bcd_data_3(bcd_data_3)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Model: owner (-1 = idle), edge index of the current grant, live vs frozen.
    int          m_owner = -1;
    int          m_g = 0;
    int          m_n = 0;
    bit          m_live = 1'b0;
    bit          m_blink = 1'b0;
    logic [15:0] m_bcd = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [N*16-1:0] mk(input int idx, input logic [15:0] v);
        logic [N*16-1:0] r;
        r = '0;
        r[16*idx +: 16] = v;
        return r;
    endfunction

    task automatic model_edge();
        int pick;
        pick = -1;
        m_n++;
        for (int i = N - 1; i >= 0; i--) if (req[i]) pick = i;
        if (m_owner < 0) begin
            if (pick >= 0) begin m_owner = pick; m_g = m_n; m_live = 1'b1; end
        end else if (m_n - m_g < H) begin
            m_live = req[m_owner];
        end else if (!(m_live && req[m_owner] && pick == m_owner)) begin
            if (pick >= 0) begin m_owner = pick; m_g = m_n; m_live = 1'b1; end
            else begin m_owner = -1; m_live = 1'b0; end
        end
        if (m_owner >= 0 && m_live) begin
            m_bcd   = req_bcd[16*m_owner +: 16];
            m_blink = req_blink[m_owner];
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [N-1:0] eg;
        logic         ev;
        eg = '0;
        if (m_owner >= 0) eg[m_owner] = 1'b1;
        ev = m_owner >= 0 && (!m_blink || ((m_n - m_g) / B) % 2 == 0);
        check({tag, ".grant"}, 32'(grant), 32'(eg));
        check({tag, ".owner"}, 32'(owner_id), 32'(m_owner >= 0 ? m_owner : 0));
        check({tag, ".valid"}, 32'(valid), 32'(ev));
        check({tag, ".digits"}, 32'({bcd_data_3, bcd_data_2, bcd_data_1, bcd_data_0}),
              32'(m_owner >= 0 ? m_bcd : 16'h0));
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N*16-1:0] d, input logic [N-1:0] bl,
                        input string tag);
        @(negedge clk);
        req = r; req_bcd = d; req_blink = bl;
        @(posedge clk);
        model_edge();
        #1 check_outputs(tag);
    endtask

    initial begin
        logic [N-1:0] r;
        logic [N-1:0] bl;
        logic [N*16-1:0] d;
        repeat (3) @(posedge clk);
        #1 check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step('0, '0, '0, "idle");

        step(4'b0100, mk(2, 16'h1234), '0, "single");
        check("single.explicit_grant", 32'(grant), 32'h4);
        check("single.explicit_digits", 32'({bcd_data_3, bcd_data_2, bcd_data_1, bcd_data_0}), 32'h1234);
        step(4'b0100, mk(2, 16'h0009), '0, "single_change");
        check("single.explicit_0009", 32'({bcd_data_3, bcd_data_2, bcd_data_1, bcd_data_0}), 32'h0009);
        repeat (5) step('0, '0, '0, "release");

        step(4'b0100, mk(2, 16'h5555), '0, "nopre_grant");
        repeat (6) step(4'b0101, mk(2, 16'h5555) | mk(0, 16'h7777), '0, "nopre");
        check("nopre.explicit_final", 32'(grant), 32'h1);
        repeat (6) step('0, '0, '0, "drain");

        step(4'b0010, mk(1, 16'h0042), '0, "linger_grant");
        repeat (6) step('0, mk(1, 16'h0099), '0, "linger");
        step(4'b0010, mk(1, 16'h0042), '0, "linger2_grant");
        step('0, mk(1, 16'h0011), '0, "linger2");
        repeat (5) step(4'b1000, mk(3, 16'h3333), '0, "linger2_handover");
        repeat (6) step('0, '0, '0, "drain");

        repeat (6) step(4'b0001, mk(0, 16'h8888), 4'b0001, "blink");
        repeat (10) step(4'b0010, mk(1, 16'h2222), 4'b0001, "blink_regrant");
        repeat (6) step('0, '0, '0, "drain");

        step(4'b0100, mk(2, 16'h0777), '0, "arst_grant");
        step('0, '0, '0, "arst_linger");
        @(negedge clk);
        #2 rst_n = 1'b0;
        m_owner = -1; m_live = 1'b0;
        #1 check_outputs("arst_immediate");
        @(posedge clk);
        #1 check_outputs("arst_held");
        @(negedge clk);
        rst_n = 1'b1; req = 4'b0010; req_bcd = mk(1, 16'h4321);
        @(posedge clk);
        model_edge();
        #1 check_outputs("arst_release");

        r = '0; bl = '0; d = '0;
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(7) == 0) r[i] = ~r[i];
                if ($urandom_range(15) == 0) bl[i] = ~bl[i];
            end
            if ($urandom_range(3) == 0) d = {$urandom, $urandom};
            step(r, d, bl, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/seg7_display_arbiter.md
# seg7_display_arbiter

Shares the board's single 4-digit seven-segment display between up to NUM_REQ independent requesters, such as the countdown timer, matrix-calculator status and error-code reporters. It grants ownership by fixed priority and enforces a minimum on-screen hold time so the display does not flicker. It optionally blinks the owner's digits. It sits between the requesting blocks and the `seg7_display` driver, whose `valid` and `bcd_data_0..3` inputs it supplies.

## Interface
- NUM_REQ, 4: number of requesters; index 0 has the highest priority; legal range 2..8.
- HOLD_CYCLES, 50_000_000: minimum display time per grant in clk cycles (0.5 s at 100 MHz); must be ≥1.
- BLINK_CYCLES, 25_000_000: half-period of the blink pattern in clk cycles; must be ≥1.
- clk  input  1  system clock, 100 MHz.
- rst_n  input  1  asynchronous active-low reset; one clock domain.
- req  input  NUM_REQ  level request per requester; held high for as long as that requester wants the display.
- req_bcd  input  NUM_REQ*16  per-requester digits; slice [16i+15:16i] belongs to requester i; nibble 0 is the rightmost digit.
- req_blink  input  NUM_REQ  per-requester blink enable.
- grant  output  NUM_REQ  one-hot current owner; all zero when idle.
- owner_id  output  3  binary index of the owner; 0 when idle.
- valid  output  1  to `seg7_display`; when low, the display is blanked.
- bcd_data_0..3  output  4 each  digits to `seg7_display`.

## Operation
- States:
  - IDLE: no owner; the display is blank.
  - SHOW: the owner holds `req`; its digits are tracked live.
  - LINGER: the owner has released `req` before its hold expired; the last digits stay frozen.
- Hold counter `hold_cnt` loads HOLD_CYCLES-1 on every new grant and decrements to 0 on each cycle in SHOW or LINGER. It saturates at 0. The hold is "expired" when `hold_cnt`==0.
- Arbitration picks `pick`, the lowest-index bit set in `req`. All transitions are evaluated at the clock edge.
- IDLE:
  - If any `req` bit is set: grant `pick`, load `hold_cnt`, and go to SHOW.
  - Otherwise stay in IDLE.
- SHOW, owner's `req` high:
  - Hold not expired: stay, even if a higher-priority request arrives. There is no preemption during the hold.
  - Hold expired and `pick`≠owner: regrant to `pick` (higher priority only, since the owner is still requesting) and reload `hold_cnt`.
  - Hold expired and `pick`==owner: keep the owner indefinitely.
- SHOW, owner's `req` low:
  - Hold not expired: go to LINGER. Digits and blink bit freeze at their last SHOW values.
  - Hold expired: if any `req` bit is set, grant `pick` directly (no IDLE cycle); otherwise go to IDLE.
- LINGER:
  - If the owner re-asserts `req` before expiry, return to SHOW with the same owner; `hold_cnt` is not reloaded.
  - On expiry: grant `pick` if any `req` bit is set, otherwise go to IDLE.
- Digits:
  - In SHOW, `bcd_data_*` register the owner's `req_bcd` slice every cycle.
  - In LINGER, they are frozen.
  - In IDLE, they are 0.
- Blink:
  - A phase counter counts 0..BLINK_CYCLES-1; a phase bit toggles on wrap.
  - The counter and phase clear on every new grant.
  - `valid` = 1 in SHOW or LINGER when the effective blink bit is 0. When the blink bit is 1, `valid` = NOT phase, so the first half-period is lit.
- Requests on indices ≥ NUM_REQ do not exist. Simultaneous requests resolve strictly by index.

## Timing
- Reset (asynchronous, immediate):
  - Outputs: `grant`=0, `owner_id`=0, `valid`=0, all `bcd_data_*`=0.
  - Internal: state=IDLE, `hold_cnt`=0, blink counter and phase=0.
- Reset asserted mid-grant clears everything with no LINGER. After release, arbitration restarts from IDLE on the first clock edge.
- All outputs are registered.
- A request sampled at edge k produces `grant`, `owner_id`, `valid`=1 and that requester's digits after edge k.
- A digit change on the owner's `req_bcd` appears one cycle later.
- A grant lasts at least HOLD_CYCLES cycles. The owner changes no earlier than edge k+HOLD_CYCLES after the grant at edge k.
- A handover is a single-edge switch: `grant` is never multi-hot and never passes through zero between two owners.

## Test plan
Parameters for all scenarios: HOLD_CYCLES=4, BLINK_CYCLES=2.

- Reset/idle: hold `rst_n` low, then release with `req`=0 → `grant`=0, `valid`=0, digits 0 for 10 cycles.
- Single request: raise `req[2]` with `req_bcd` slice 0x1234 → after 1 edge, `grant`=0100, `owner_id`=2, `valid`=1, `bcd_data_3..0`=1,2,3,4. Change the slice to 0x0009 → display shows 0,0,0,9 one cycle later.
- No preemption during hold: `req[2]` owns; raise `req[0]` 1 cycle after the grant → `grant` stays 0100 until edge 4 after the grant, then becomes 0001 in a single edge.
- Linger: `req[1]` granted, then dropped after 1 cycle with digits 0x0042 → `valid`=1 and 0,0,4,2 frozen until hold expiry, then `grant`=0 and `valid`=0. Repeat with `req[3]` high during the linger → direct handover to 3 at expiry, with no idle cycle.
- Blink: grant `req[0]` with `req_blink[0]`=1 → `valid` pattern 1,1,0,0,1,1… starting on the grant edge. Regrant to a non-blinking requester → `valid` steady 1.
- Async reset mid-LINGER: assert `rst_n` low between clock edges → all outputs 0 immediately. After release with `req[1]` high → granted on the first edge.
